// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and encodings for the datapath sequencer:
//               FSM state enum, instruction opcode/op fields, decoded
//               instruction kind, ALU operation and shifter codes.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  // Instruction opcode field [15:13]
  localparam logic [2:0] C_OPC_MOV = 3'b110;
  localparam logic [2:0] C_OPC_ALU = 3'b101;

  // Instruction op field [12:11]
  localparam logic [1:0] C_OP_MOV_IMM = 2'b10;
  localparam logic [1:0] C_OP_MOV_REG = 2'b00;
  localparam logic [1:0] C_OP_ADD     = 2'b00;
  localparam logic [1:0] C_OP_CMP     = 2'b01;
  localparam logic [1:0] C_OP_AND     = 2'b10;
  localparam logic [1:0] C_OP_MVN     = 2'b11;

  // ALU operation codes driven on ALUop
  localparam logic [1:0] C_ALUOP_ADD = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB = 2'b01;
  localparam logic [1:0] C_ALUOP_AND = 2'b10;
  localparam logic [1:0] C_ALUOP_NOT = 2'b11;

  // B-operand shifter codes driven on shift
  localparam logic [1:0] C_SH_NONE = 2'b00;
  localparam logic [1:0] C_SH_LSL  = 2'b01;
  localparam logic [1:0] C_SH_LSR  = 2'b10;
  localparam logic [1:0] C_SH_ASR  = 2'b11;

  // Decoded instruction kind
  typedef enum logic [2:0] {
    K_ILLEGAL = 3'd0,
    K_MOV_IMM = 3'd1,
    K_MOV_REG = 3'd2,
    K_ADD     = 3'd3,
    K_CMP     = 3'd4,
    K_AND     = 3'd5,
    K_MVN     = 3'd6
  } kind_t;

  // Map opcode/op onto an instruction kind; anything unlisted is illegal
  function automatic kind_t classify(input logic [2:0] opcode, input logic [1:0] op);
    kind_t k;
    k = K_ILLEGAL;
    if (opcode == C_OPC_MOV) begin
      if (op == C_OP_MOV_IMM)      k = K_MOV_IMM;
      else if (op == C_OP_MOV_REG) k = K_MOV_REG;
    end else if (opcode == C_OPC_ALU) begin
      case (op)
        C_OP_ADD: k = K_ADD;
        C_OP_CMP: k = K_CMP;
        C_OP_AND: k = K_AND;
        default:  k = K_MVN;
      endcase
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Combinational field extraction for the latched instruction:
//               register indices, op, shift code, instruction kind and the
//               sign-extended 8-bit immediate.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       i_instr,
  output logic [2:0]        o_rn,
  output logic [2:0]        o_rd,
  output logic [2:0]        o_rm,
  output logic [1:0]        o_op,
  output logic [1:0]        o_sh,
  output kind_t             o_kind,
  output logic [DATA_W-1:0] o_sximm8
);

  assign o_rn     = i_instr[10:8];
  assign o_rd     = i_instr[7:5];
  assign o_rm     = i_instr[2:0];
  assign o_op     = i_instr[12:11];
  assign o_sh     = i_instr[4:3];
  assign o_kind   = classify(i_instr[15:13], i_instr[12:11]);
  // Immediate is replicated from bit 7 up to the datapath width
  assign o_sximm8 = {{(DATA_W-8){i_instr[7]}}, i_instr[7:0]};

endmodule
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : datapath_sequencer
// Description : Moore FSM that latches a 16-bit instruction on start and
//               sequences register-file reads, ALU use and write-back strobes
//               for an external datapath.
//               Optional build macro ILLEGAL_TRAP_EN adds an 'illegal' output
//               that pulses during the DECODE cycle of an illegal encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [15:0]       in,
  output logic              w,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm8
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instr;

  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [2:0]  w_rm;
  logic [1:0]  w_op;
  logic [1:0]  w_sh;
  kind_t       w_kind;

  instr_decoder #(
    .DATA_W (DATA_W)
  ) u_decoder (
    .i_instr  (r_instr),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_rm     (w_rm),
    .o_op     (w_op),
    .o_sh     (w_sh),
    .o_kind   (w_kind),
    .o_sximm8 (sximm8)
  );

  // State register; the instruction is captured only when start is accepted in WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_instr <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && s) begin
        r_instr <= in;
      end
    end
  end

  // Next-state and Moore outputs from the current state and latched instruction
  always_comb begin
    w_next   = r_state;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    ALUop    = 2'b00;
    shift    = 2'b00;
`ifdef ILLEGAL_TRAP_EN
    illegal  = 1'b0;
`endif
    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_kind)
          K_MOV_IMM:             w_next = S_WRITE_IMM;
          K_MOV_REG, K_MVN:      w_next = S_GET_B;
          K_ADD, K_CMP, K_AND:   w_next = S_GET_A;
          default: begin
            w_next = S_WAIT;
`ifdef ILLEGAL_TRAP_EN
            illegal = 1'b1;
`endif
          end
        endcase
      end
      S_WRITE_IMM: begin
        vsel     = 1'b1;
        write    = 1'b1;
        writenum = w_rn;
        w_next   = S_WAIT;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = S_GET_B;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_ALU;
      end
      S_ALU: begin
        shift = w_sh;
        bsel  = 1'b0;
        // MOV reg and MVN use only the B path, so A is forced to zero
        asel  = (w_kind == K_MOV_REG) || (w_kind == K_MVN);
        ALUop = (w_kind == K_MOV_REG) ? C_ALUOP_ADD : w_op;
        if (w_kind == K_CMP) begin
          loads  = 1'b1;
          w_next = S_WAIT;
        end else begin
          loadc  = 1'b1;
          w_next = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        vsel     = 1'b0;
        write    = 1'b1;
        writenum = w_rd;
        w_next   = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_sequencer
// Description : Self-checking bench for datapath_sequencer. Directed and
//               random instructions are compared cycle by cycle against an
//               instruction-level model of the expected strobe sequence; a
//               small behavioural datapath checks register results.
//               Honours ILLEGAL_TRAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_datapath_sequencer;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              s;
  logic [15:0]       in;
  logic              w;
  logic [2:0]        readnum;
  logic [2:0]        writenum;
  logic              vsel, loada, loadb, asel, bsel, loadc, loads, write;
  logic [1:0]        ALUop;
  logic [1:0]        shift;
  logic [DATA_W-1:0] sximm8;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal;
`endif

  // Free-running clock
  always #5 clk = ~clk;

  datapath_sequencer #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .in       (in),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .asel     (asel),
    .bsel     (bsel),
    .loadc    (loadc),
    .loads    (loads),
    .write    (write),
    .ALUop    (ALUop),
    .shift    (shift),
    .sximm8   (sximm8)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal  (illegal)
`endif
  );

  // {w, readnum, writenum, vsel, loada, loadb, asel, bsel, loadc, loads, write, ALUop, shift, illegal}
  typedef logic [19:0] vec_t;
  typedef struct {
    vec_t              v;
    logic [DATA_W-1:0] sx;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic w_, input logic [2:0] rn, input logic [2:0] wn,
                              input logic vs, input logic la, input logic lb, input logic as_,
                              input logic bs, input logic lc, input logic ls, input logic wr,
                              input logic [1:0] aop, input logic [1:0] sh, input logic ill);
    return {w_, rn, wn, vs, la, lb, as_, bs, lc, ls, wr, aop, sh, ill};
  endfunction

  function automatic vec_t obs_vec();
    logic ill;
`ifdef ILLEGAL_TRAP_EN
    ill = illegal;
`else
    ill = 1'b0;
`endif
    return {w, readnum, writenum, vsel, loada, loadb, asel, bsel, loadc, loads, write, ALUop, shift, ill};
  endfunction

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b);
    int v;
    v = (int'(b) > 127) ? int'(b) - 256 : int'(b);
    return v[DATA_W-1:0];
  endfunction

  function automatic logic trap_on();
`ifdef ILLEGAL_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Instruction-level model: list the control vector of each busy cycle, then idle
  function automatic void model(input logic [15:0] ins);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic is_movi, is_movr, is_alu, legal, uses_a, a_zero, is_cmp;
    logic [DATA_W-1:0] sx;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
    rd  = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
    sx  = sext8(ins[7:0]);
    is_movi = (opc == 3'b110) && (op == 2'b10);
    is_movr = (opc == 3'b110) && (op == 2'b00);
    is_alu  = (opc == 3'b101);
    legal   = is_movi || is_movr || is_alu;
    exp_q.push_back('{mk(0,0,0, 0,0,0,0,0,0,0,0, 2'b00,2'b00, trap_on() && !legal), sx});
    if (is_movi) begin
      exp_q.push_back('{mk(0,0,rn, 1,0,0,0,0,0,0,1, 2'b00,2'b00, 0), sx});
    end else if (legal) begin
      uses_a = is_alu && (op != 2'b11);
      a_zero = !uses_a;
      is_cmp = is_alu && (op == 2'b01);
      if (uses_a) exp_q.push_back('{mk(0,rn,0, 0,1,0,0,0,0,0,0, 2'b00,2'b00, 0), sx});
      exp_q.push_back('{mk(0,rm,0, 0,0,1,0,0,0,0,0, 2'b00,2'b00, 0), sx});
      exp_q.push_back('{mk(0,0,0, 0,0,0,a_zero,0,!is_cmp,is_cmp,0,
                           is_movr ? 2'b00 : op, sh, 0), sx});
      if (!is_cmp) exp_q.push_back('{mk(0,0,rd, 0,0,0,0,0,0,0,1, 2'b00,2'b00, 0), sx});
    end
    exp_q.push_back('{mk(1,0,0, 0,0,0,0,0,0,0,0, 2'b00,2'b00, 0), sx});
  endfunction

  // Behavioural datapath attached to the sequencer outputs
  logic [DATA_W-1:0] dp_r [8];
  logic [DATA_W-1:0] dp_a, dp_b, dp_c;

  function automatic logic [DATA_W-1:0] dp_alu(input logic [1:0] aop, input logic [1:0] sh,
                                               input logic as_, input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] ain, bin;
    ain = as_ ? '0 : a;
    case (sh)
      2'b00:   bin = b;
      2'b01:   bin = b << 1;
      2'b10:   bin = b >> 1;
      default: bin = {b[DATA_W-1], b[DATA_W-1:1]};
    endcase
    case (aop)
      2'b00:   return ain + bin;
      2'b01:   return ain - bin;
      2'b10:   return ain & bin;
      default: return ~bin;
    endcase
  endfunction

  // Register file, A/B/C registers updated by the sequencer strobes
  always @(posedge clk) begin
    if (write) dp_r[writenum] <= vsel ? sximm8 : dp_c;
    if (loada) dp_a <= dp_r[readnum];
    if (loadb) dp_b <= dp_r[readnum];
    if (loadc) dp_c <= dp_alu(ALUop, shift, asel, dp_a, dp_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ctrl"}, 32'(obs_vec()), 32'(mk(1,0,0, 0,0,0,0,0,0,0,0, 2'b00,2'b00, 0)));
    check({tag, " sximm8"}, 32'(sximm8), 32'h0);
  endtask

  // Issue one instruction and compare every busy cycle plus the return to WAIT
  task automatic run(input logic [15:0] ins);
    exp_t e;
    int   step;
    step = 0;
    model(ins);
    @(negedge clk); s = 1'b1; in = ins;
    @(negedge clk); s = 1'b0; in = 16'($urandom);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("ins %h step %0d ctrl", ins, step), 32'(obs_vec()), 32'(e.v));
      check($sformatf("ins %h step %0d sximm8", ins, step), 32'(sximm8), 32'(e.sx));
      step++;
      if (exp_q.size() > 0) begin
        s = 1'($urandom);
        @(negedge clk);
      end else begin
        s = 1'b0;
      end
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] x;
    x = 16'($urandom);
    case ($urandom_range(0, 6))
      0: x[15:11] = 5'b11010;
      1: x[15:11] = 5'b11000;
      2: x[15:11] = 5'b10100;
      3: x[15:11] = 5'b10101;
      4: x[15:11] = 5'b10110;
      5: x[15:11] = 5'b10111;
      default: begin
        if ($urandom_range(0, 1) == 1) x[15:11] = ($urandom_range(0, 1) == 1) ? 5'b11001 : 5'b11011;
        else x[15:13] = 3'($urandom_range(0, 4));
      end
    endcase
    return x;
  endfunction

  // Guard against a hung run
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed steps followed by random instructions
  initial begin
    reset = 1'b1; s = 1'b0; in = 16'h0000;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("idle s=0");

    run(16'hD007);                 // MOV R0,#7
    run(16'hD102);                 // MOV R1,#2
    run(16'hA148);                 // ADD R2,R1,R0,LSL#1
    check("R2 after ADD", 32'(dp_r[2]), 32'd16);
    run(16'hA801);                 // CMP R0,R1
    run(16'hB861);                 // MVN R3,R1
    check("R3 after MVN", 32'(dp_r[3]), 32'(16'hFFFD));
    run(16'hD5FF);                 // MOV R5,#-1
    check("R5 after MOV", 32'(dp_r[5]), 32'(16'hFFFF));
    run(16'h0000);                 // illegal

    // Reset wins over start while in WAIT
    @(negedge clk); reset = 1'b1; s = 1'b1; in = 16'hD007;
    @(negedge clk); reset = 1'b0; s = 1'b0;
    check_idle("reset over s");
    @(negedge clk);
    check_idle("reset over s hold");

    // Reset during GET_B of an ADD: back to WAIT, no write afterwards
    @(negedge clk); s = 1'b1; in = 16'hA148;
    @(negedge clk); s = 1'b0;      // DECODE
    @(negedge clk);                // GET_A
    @(negedge clk);                // GET_B
    check("midreset GET_B readnum", 32'(readnum), 32'd0);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_idle("midreset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("midreset no write %0d", i), 32'(write), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      run(rand_instr());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
